// File: rtl/weight_feeder_pkg.sv
// Shared widths and FSM state encodings for the weight feeder and its MAC neighbour.
package weight_feeder_pkg;
   localparam int DATA_SIZE = 8;
   localparam int MAC_WIDTH = 2 * DATA_SIZE + 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } wf_state_t;
endpackage

// File: rtl/weight_feeder_sync_fifo.sv
// Single-clock FIFO with combinational head word; push on full and pop on empty are dropped.
module sync_fifo #(
   parameter int DATA_SIZE = 8,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] wr_data,
   output logic [DATA_SIZE-1:0] head,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_W-1:0]     count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointer widths equal log2(DEPTH), so the increment wraps for free.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/weight_feeder.sv
// Buffers weights from memory and hands exactly tile_len of them to a mac_unit on request.
//  state     | meaning
//  ST_IDLE   | waiting for start; requests ignored
//  ST_STREAM | serving win_request until remaining reaches zero
module weight_feeder
   import weight_feeder_pkg::*;
#(
   parameter int DATA_SIZE = weight_feeder_pkg::DATA_SIZE,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 start,
   input  logic [CNT_W-1:0]     tile_len,
   input  logic                 win_request,
   output logic [DATA_SIZE-1:0] win,
   output logic                 win_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun
);
   wf_state_t            state_q, state_d;
   logic [CNT_W-1:0]     remaining_q, remaining_d;
   logic [DATA_SIZE-1:0] win_q, win_d;
   logic                 win_valid_q, win_valid_d;
   logic                 done_q, done_d;
   logic                 underrun_q, underrun_d;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_SIZE-1:0] fifo_head;
   logic [CNT_W-1:0]     fifo_count;

   assign wr_ready  = ~fifo_full;
   assign fifo_push = wr_valid & ~fifo_full;
   assign fifo_pop  = (state_q == ST_STREAM) & win_request & ~fifo_empty;

   sync_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .CNT_W     (CNT_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (wr_data),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      win_d       = win_q;
      win_valid_d = 1'b0;
      done_d      = 1'b0;
      underrun_d  = underrun_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               underrun_d = 1'b0;
               if (tile_len != '0) begin
                  remaining_d = tile_len;
                  state_d     = ST_STREAM;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (win_request) begin
               if (fifo_pop) begin
                  win_d       = fifo_head;
                  win_valid_d = 1'b1;
                  remaining_d = remaining_q - 1'b1;
                  // Last weight: done lines up with its win_valid.
                  if (remaining_q == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  underrun_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
      end
   end

   assign win       = win_q;
   assign win_valid = win_valid_q;
   assign busy      = (state_q == ST_STREAM);
   assign done      = done_q;
   assign underrun  = underrun_q;
endmodule

// File: tb/tb_weight_feeder.sv
// Directed and random stimulus for weight_feeder, checked against a queue-based reference model.
module tb_weight_feeder;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic [CW-1:0] tile_len = '0;
   logic          win_request = 1'b0;
   logic [DW-1:0] win;
   logic          win_valid, busy, done, underrun;

   int checks = 0;
   int errors = 0;

   // Reference model: a tile is "open" with some weights still owed.
   logic [DW-1:0] mq[$];
   bit            m_open;
   int            m_owed;
   logic [DW-1:0] e_win;
   bit            e_valid, e_done, e_under;

   weight_feeder #(.DATA_SIZE(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .start       (start),
      .tile_len    (tile_len),
      .win_request (win_request),
      .win         (win),
      .win_valid   (win_valid),
      .busy        (busy),
      .done        (done),
      .underrun    (underrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".win"},       32'(win),       32'(e_win));
      chk({tag, ".win_valid"}, 32'(win_valid), 32'(e_valid));
      chk({tag, ".busy"},      32'(busy),      32'(m_open));
      chk({tag, ".done"},      32'(done),      32'(e_done));
      chk({tag, ".underrun"},  32'(underrun),  32'(e_under));
      chk({tag, ".wr_ready"},  32'(wr_ready),  32'(mq.size() < DEPTH));
   endtask

   task automatic model_reset();
      mq.delete();
      m_open  = 0;
      m_owed  = 0;
      e_win   = '0;
      e_valid = 0;
      e_done  = 0;
      e_under = 0;
   endtask

   // Drive at the falling edge, let one rising edge pass, advance model, check.
   task automatic step(input string tag, input bit wv, input logic [DW-1:0] wd,
                       input bit st, input int tl, input bit req);
      bit was_full, was_empty;
      wr_valid = wv; wr_data = wd; start = st; tile_len = CW'(tl); win_request = req;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      @(posedge clock);
      e_valid = 0;
      e_done  = 0;
      if (!m_open) begin
         if (st) begin
            e_under = 0;
            if (tl != 0) begin m_open = 1; m_owed = tl; end
            else e_done = 1;
         end
      end else if (req) begin
         if (!was_empty) begin
            e_win   = mq.pop_front();
            e_valid = 1;
            m_owed--;
            if (m_owed == 0) begin m_open = 0; e_done = 1; end
         end else begin
            e_under = 1;
         end
      end
      if (wv && !was_full) mq.push_back(wd);
      #1;
      chk_all(tag);
      @(negedge clock);
      wr_valid = 0; start = 0; win_request = 0;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, '0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      // 1: reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'($urandom); wr_data = DW'($urandom); start = 1'($urandom);
         tile_len = CW'($urandom); win_request = 1'($urandom);
         @(negedge clock);
         chk_all("reset");
      end
      wr_valid = 0; start = 0; win_request = 0;
      reset = 1'b1;
      @(negedge clock);

      // 2: basic tile
      step("t2.push", 1, 8'd4, 0, 0, 0);
      step("t2.push", 1, 8'd5, 0, 0, 0);
      step("t2.push", 1, 8'd6, 0, 0, 0);
      step("t2.start", 0, '0, 1, 3, 0);
      for (int i = 0; i < 3; i++) step("t2.req", 0, '0, 0, 0, 1);
      idle("t2.idle", 2);

      // 3: fill past full, then drain in order
      for (int i = 0; i < 17; i++) step("t3.push", 1, DW'(8'h40 + i), 0, 0, 0);
      step("t3.start", 0, '0, 1, 16, 0);
      for (int i = 0; i < 16; i++) step("t3.req", 0, '0, 0, 0, 1);

      // 4: underrun then recovery
      step("t4.start", 0, '0, 1, 2, 0);
      step("t4.req_empty", 0, '0, 0, 0, 1);
      step("t4.push", 1, 8'd9, 0, 0, 0);
      step("t4.req", 0, '0, 0, 0, 1);
      idle("t4.hold", 2);
      step("t4.push", 1, DW'($urandom), 0, 0, 0);
      step("t4.req_last", 0, '0, 0, 0, 1);
      step("t4.start_clr", 0, '0, 1, 0, 0);

      // 5: zero-length tile, push+pop at count 8, pointer wrap
      step("t5.zero", 0, '0, 1, 0, 0);
      idle("t5.zero_idle", 2);
      for (int i = 0; i < 8; i++) step("t5.fill", 1, DW'($urandom), 0, 0, 0);
      step("t5.start", 0, '0, 1, 4, 0);
      for (int i = 0; i < 4; i++) step("t5.pushpop", 1, DW'($urandom), 0, 0, 1);
      step("t5.start8", 0, '0, 1, 8, 0);
      for (int i = 0; i < 8; i++) step("t5.drain", 0, '0, 0, 0, 1);
      for (int t = 0; t < 4; t++) begin
         step("t5.wstart", 1, DW'($urandom), 1, 10, 0);
         for (int i = 0; i < 12; i++) step("t5.wrap", 1, DW'($urandom), 0, 0, 1);
      end
      step("t5.flush", 0, '0, 1, mq.size(), 0);
      for (int i = 0; i < 16 && m_open; i++) step("t5.flush_req", 0, '0, 0, 0, 1);

      // 6: reset mid-tile
      for (int i = 0; i < 5; i++) step("t6.fill", 1, DW'($urandom), 0, 0, 0);
      step("t6.start", 0, '0, 1, 5, 0);
      step("t6.req", 0, '0, 0, 0, 1);
      step("t6.req", 0, '0, 0, 0, 1);
      #2 reset = 1'b0;
      model_reset();
      #1 chk_all("t6.in_reset");
      @(negedge clock);
      reset = 1'b1;
      idle("t6.after", 2);
      step("t6.req_idle", 0, '0, 0, 0, 1);
      step("t6.push", 1, 8'hA5, 0, 0, 0);
      step("t6.push", 1, 8'h5A, 0, 0, 0);
      step("t6.restart", 0, '0, 1, 2, 0);
      step("t6.req", 0, '0, 0, 0, 1);
      step("t6.req", 0, '0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 2) != 0), DW'($urandom),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 6),
              1'($urandom_range(0, 2) != 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
